inst_queue: RTL and testbench

Instruction queue between the fetch path and decode. It captures the two-instruction fetch group produced at each program-counter step (PC advances by 8 bytes) and presents up to two oldest instructions to decode per cycle. It drives `iq_full` back to the PC controller so PC advance stalls before entries can be lost, and it empties on branch flush.

---
 rtl/iq_pkg.sv | 21 ++
 rtl/iq_regfile.sv | 39 +++
 rtl/inst_queue.sv | 119 +++++++++++
 tb/tb_inst_queue.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
// ============================================================================
// iq_pkg : shared constants and entry type for the instruction queue
// Rev 1.0
// ============================================================================
`default_nettype none

package iq_pkg;

  localparam int INST_W    = 32;
  localparam int PC_W      = 4;
  localparam int PC_STEP   = 8;
  localparam int SLOT_STEP = 4;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } iq_entry_t;

endpackage

`default_nettype wire

// File: rtl/iq_regfile.sv
// ============================================================================
// iq_regfile : DEPTH-entry queue storage, two write and two combinational read ports
// Rev 1.0
// ============================================================================
`default_nettype none

module iq_regfile
  import iq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr0,
  input  logic [$clog2(DEPTH)-1:0] waddr1,
  input  iq_entry_t                wdata0,
  input  iq_entry_t                wdata1,
  input  logic [$clog2(DEPTH)-1:0] raddr0,
  input  logic [$clog2(DEPTH)-1:0] raddr1,
  output iq_entry_t                rdata0,
  output iq_entry_t                rdata1
);

  iq_entry_t mem [DEPTH];

  // Both slots of a fetch pair land together; the addresses never collide.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr0] <= wdata0;
      mem[waddr1] <= wdata1;
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

`default_nettype wire

// File: rtl/inst_queue.sv
// ============================================================================
// inst_queue : fetch-pair instruction queue feeding decode, with PC-stall and flush
// Rev 1.0
// ============================================================================
`default_nettype none

module inst_queue #(
  parameter int DEPTH       = 8,
  parameter int INST_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int FULL_MARGIN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   enq_valid,
  input  logic [INST_W-1:0]      enq_inst0,
  input  logic [INST_W-1:0]      enq_inst1,
  input  logic [ADDR_W-1:0]      enq_pc,
  input  logic [1:0]             deq_take,
  output logic                   deq_valid0,
  output logic                   deq_valid1,
  output logic [INST_W-1:0]      deq_inst0,
  output logic [INST_W-1:0]      deq_inst1,
  output logic [ADDR_W-1:0]      deq_pc0,
  output logic [ADDR_W-1:0]      deq_pc1,
  output logic                   iq_full,
  output logic                   iq_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic             accept;
  logic [1:0]       take_req;
  logic [1:0]       take_eff;
  iq_pkg::iq_entry_t wr0, wr1, rd0, rd1;

  // Storage entry widths follow iq_pkg; INST_W/ADDR_W must match it.
  assign wr0 = '{inst: enq_inst0, pc: enq_pc};
  assign wr1 = '{inst: enq_inst1, pc: enq_pc + ADDR_W'(iq_pkg::SLOT_STEP)};

  iq_regfile #(
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk    (clk),
    .we     (accept),
    .waddr0 (tail_q),
    .waddr1 (tail_q + PTR_W'(1)),
    .wdata0 (wr0),
    .wdata1 (wr1),
    .raddr0 (head_q),
    .raddr1 (head_q + PTR_W'(1)),
    .rdata0 (rd0),
    .rdata1 (rd1)
  );

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;

    // Room is judged on start-of-cycle occupancy; same-cycle dequeue frees nothing.
    accept   = enq_valid && !flush && ((CNT_W'(DEPTH) - count_q) >= CNT_W'(2));
    take_req = (deq_take == 2'd3) ? 2'd2 : deq_take;
    take_eff = (CNT_W'(take_req) > count_q) ? count_q[1:0] : take_req;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (accept) begin
        tail_d = tail_q + PTR_W'(2);
      end
      if (enq_valid && !accept) begin
        err_d = 1'b1;
      end
      head_d  = head_q + PTR_W'(take_eff);
      count_d = count_q + (accept ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(take_eff);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign deq_valid0   = (count_q >= CNT_W'(1));
  assign deq_valid1   = (count_q >= CNT_W'(2));
  assign deq_inst0    = deq_valid0 ? rd0.inst : '0;
  assign deq_pc0      = deq_valid0 ? rd0.pc   : '0;
  assign deq_inst1    = deq_valid1 ? rd1.inst : '0;
  assign deq_pc1      = deq_valid1 ? rd1.pc   : '0;
  assign iq_full      = (count_q > CNT_W'(DEPTH - FULL_MARGIN));
  assign iq_empty     = (count_q == '0);
  assign count        = count_q;
  assign err_overflow = err_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_queue.sv
// ============================================================================
// tb_inst_queue : randomized scoreboard bench for inst_queue against a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        enq_valid = 1'b0;
  logic [31:0] enq_inst0 = '0;
  logic [31:0] enq_inst1 = '0;
  logic [3:0]  enq_pc = '0;
  logic [1:0]  deq_take = '0;
  logic        deq_valid0, deq_valid1;
  logic [31:0] deq_inst0, deq_inst1;
  logic [3:0]  deq_pc0, deq_pc1;
  logic        iq_full, iq_empty, err_overflow;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  inst_queue #(
    .DEPTH       (8),
    .INST_W      (32),
    .ADDR_W      (4),
    .FULL_MARGIN (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .enq_valid    (enq_valid),
    .enq_inst0    (enq_inst0),
    .enq_inst1    (enq_inst1),
    .enq_pc       (enq_pc),
    .deq_take     (deq_take),
    .deq_valid0   (deq_valid0),
    .deq_valid1   (deq_valid1),
    .deq_inst0    (deq_inst0),
    .deq_inst1    (deq_inst1),
    .deq_pc0      (deq_pc0),
    .deq_pc1      (deq_pc1),
    .iq_full      (iq_full),
    .iq_empty     (iq_empty),
    .count        (count),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  pc;
  } ent_t;

  typedef struct {
    logic [3:0]  cnt;
    logic        v0, v1;
    logic [31:0] i0, i1;
    logic [3:0]  p0, p1;
    logic        full, empty, err;
  } exp_t;

  ent_t mq[$];
  bit   merr = 1'b0;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model_view();
    exp_t e;
    int   n = mq.size();
    e.cnt   = 4'(n);
    e.v0    = (n >= 1);
    e.v1    = (n >= 2);
    e.i0    = (n >= 1) ? mq[0].inst : 32'h0;
    e.p0    = (n >= 1) ? mq[0].pc   : 4'h0;
    e.i1    = (n >= 2) ? mq[1].inst : 32'h0;
    e.p1    = (n >= 2) ? mq[1].pc   : 4'h0;
    e.full  = (n > 4);
    e.empty = (n == 0);
    e.err   = merr;
    return e;
  endfunction

  // One clock of stimulus; the model's post-edge view goes to the scoreboard.
  task automatic cyc(input bit fl, input bit ev, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] pc, input logic [1:0] tk);
    int   n, t;
    bit   acc;
    ent_t e;
    @(negedge clk);
    rst = 1'b0; flush = fl; enq_valid = ev; enq_inst0 = a; enq_inst1 = b;
    enq_pc = pc; deq_take = tk;
    if (fl) begin
      mq.delete();
    end else begin
      n   = mq.size();
      acc = ev && (8 - n >= 2);
      t   = (tk == 2'd3) ? 2 : int'(tk);
      if (t > n) t = n;
      repeat (t) void'(mq.pop_front());
      if (acc) begin
        e.inst = a; e.pc = pc;          mq.push_back(e);
        e.inst = b; e.pc = pc + 4'd4;   mq.push_back(e);
      end
      if (ev && !acc) merr = 1'b1;
    end
    exp_q.push_back(model_view());
  endtask

  task automatic sync_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; enq_valid = 1'b1; deq_take = 2'd2;
    enq_inst0 = $urandom; enq_inst1 = $urandom;
    mq.delete(); merr = 1'b0;
    exp_q.push_back(model_view());
  endtask

  // Reset raised between edges must clear state without waiting for clk.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_take = 2'd0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_empty", 64'(iq_empty), 64'd1);
    chk("async_rst_valid0", 64'(deq_valid0), 64'd0);
    chk("async_rst_err", 64'(err_overflow), 64'd0);
    mq.delete(); merr = 1'b0;
    exp_q.push_back(model_view());
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("count",  64'(count),        64'(e.cnt));
        chk("valid0", 64'(deq_valid0),   64'(e.v0));
        chk("valid1", 64'(deq_valid1),   64'(e.v1));
        chk("inst0",  64'(deq_inst0),    64'(e.i0));
        chk("inst1",  64'(deq_inst1),    64'(e.i1));
        chk("pc0",    64'(deq_pc0),      64'(e.p0));
        chk("pc1",    64'(deq_pc1),      64'(e.p1));
        chk("full",   64'(iq_full),      64'(e.full));
        chk("empty",  64'(iq_empty),     64'(e.empty));
        chk("err",    64'(err_overflow), 64'(e.err));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    int r;
    sync_reset();
    // single pair, then fill to the threshold and flush with competing requests
    cyc(0, 1, 32'hA0, 32'hA1, 4'd0, 2'd0);
    cyc(0, 1, 32'hA2, 32'hA3, 4'd8, 2'd0);
    cyc(0, 1, 32'hA4, 32'hA5, 4'd0, 2'd0);
    cyc(1, 1, 32'hEE, 32'hEF, 4'd8, 2'd1);
    // fill to capacity, then overflow
    for (int i = 0; i < 5; i++)
      cyc(0, 1, 32'hC0 + 32'(2*i), 32'hC1 + 32'(2*i), 4'(8*i), 2'd0);
    cyc(1, 0, 32'h0, 32'h0, 4'd0, 2'd0);
    // simultaneous enqueue and dequeue at count 2
    cyc(0, 1, 32'hA0, 32'hA1, 4'd0, 2'd0);
    cyc(0, 1, 32'hB0, 32'hB1, 4'd8, 2'd2);
    // PC wrap, then pointer wrap with steady dequeue
    cyc(0, 1, 32'hD0, 32'hD1, 4'd12, 2'd2);
    for (int i = 0; i < 10; i++)
      cyc(0, 1, 32'h100 + 32'(i), 32'h200 + 32'(i), 4'(8*i), 2'd2);
    cyc(0, 0, 32'h0, 32'h0, 4'd0, 2'd3);
    async_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2)      sync_reset();
      else if (r < 4) async_reset();
      else            cyc(r < 9, $urandom_range(0, 99) < 60, $urandom, $urandom,
                          4'($urandom), 2'($urandom));
    end
    cyc(0, 0, 32'h0, 32'h0, 4'd0, 2'd0);
    @(posedge clk);
    #3;
    chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
